// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 codes, FSM state
// encoding, the main-control ALUOp code and operand-signedness decode helpers.
package muldiv_seq_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   // ALUOp value the main control unit uses to route an M-extension op to this block.
   localparam logic [3:0] ALUOP_MULDIV = 4'b1010;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PREP = 3'd1,
      ST_RUN  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   function automatic logic is_div_op(input logic [2:0] f3);
      return f3[2];
   endfunction

   function automatic logic a_is_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic b_is_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_seq_sign_fix.sv
// Conditional two's-complement negate. Used as abs() on operands in PREP (neg = signed & msb)
// and as the final sign correction of quotient, remainder or product in FIX.
module muldiv_seq_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] value,
   input  logic             neg,
   output logic [WIDTH-1:0] fixed
);

   assign fixed = neg ? -value : value;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply, restoring divide, XLEN steps.
// Optional build macro MULDIV_EARLY_OUT_EN short-circuits zero multiplies and trivial divides.
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            busy,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_t state, state_next;

   logic [CNT_W-1:0]  cnt;
   logic [2*XLEN-1:0] acc;      // {hi, lo}: product, or {remainder, quotient}
   logic [XLEN-1:0]   b_q;      // multiplicand or divisor magnitude
   logic [2:0]        f3_q;
   logic              sign_a;
   logic              sign_b;

   logic              in_fix;
   logic              prep_sa;
   logic              prep_sb;
   logic [XLEN-1:0]   lo_in, hi_in, lo_out, hi_out;
   logic              lo_neg, hi_neg;
   logic [2*XLEN-1:0] prod_fixed;

   logic              short_cut;
   logic [XLEN-1:0]   short_val;
   logic [XLEN-1:0]   fix_val;

   logic [XLEN:0]     add_sum;
   logic [2*XLEN-1:0] mul_step;
   logic [XLEN:0]     rem_sh;
   logic              div_ge;
   logic [XLEN-1:0]   div_diff;
   logic [2*XLEN-1:0] div_step;

   assign in_fix  = (state == ST_FIX);
   assign prep_sa = a_is_signed(funct3) & op_a[XLEN-1];
   assign prep_sb = b_is_signed(funct3) & op_b[XLEN-1];

   // The two XLEN-wide fixers serve as operand abs() in PREP and as quotient/remainder
   // sign correction in FIX, so only one set of negators exists per half.
   assign lo_in  = in_fix ? acc[XLEN-1:0]      : op_a;
   assign lo_neg = in_fix ? (sign_a ^ sign_b)  : prep_sa;
   assign hi_in  = in_fix ? acc[2*XLEN-1:XLEN] : op_b;
   assign hi_neg = in_fix ? sign_a             : prep_sb;

   muldiv_seq_sign_fix #(.WIDTH(XLEN)) u_fix_lo (
      .value (lo_in),
      .neg   (lo_neg),
      .fixed (lo_out)
   );

   muldiv_seq_sign_fix #(.WIDTH(XLEN)) u_fix_hi (
      .value (hi_in),
      .neg   (hi_neg),
      .fixed (hi_out)
   );

   muldiv_seq_sign_fix #(.WIDTH(2*XLEN)) u_fix_prod (
      .value (acc),
      .neg   (sign_a ^ sign_b),
      .fixed (prod_fixed)
   );

   // Multiply step: conditionally add multiplicand into the upper half, then shift right.
   assign add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, b_q};
   assign mul_step = acc[0] ? {add_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};

   // Restoring divide step; the low XLEN bits of the difference are exact whenever it is kept.
   assign rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
   assign div_ge   = (rem_sh >= {1'b0, b_q});
   assign div_diff = rem_sh[XLEN-1:0] - b_q;
   assign div_step = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1}
                            : {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};

   // Special cases resolved in PREP without iterating; inputs are held by the stalled pipeline.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      short_cut = 1'b0;
      short_val = '0;
      if (is_div_op(funct3) && (op_b == '0)) begin
         short_cut = 1'b1;
         short_val = funct3[1] ? op_a : '1;
      end else if (is_div_op(funct3) && !funct3[0] && (op_a == INT_MIN) && (op_b == '1)) begin
         short_cut = 1'b1;
         short_val = funct3[1] ? '0 : INT_MIN;
      end
`ifdef MULDIV_EARLY_OUT_EN
      else if (!is_div_op(funct3) && ((op_a == '0) || (op_b == '0))) begin
         short_cut = 1'b1;
         short_val = '0;
      end else if (is_div_op(funct3) && (lo_out < hi_out)) begin
         short_cut = 1'b1;
         short_val = funct3[1] ? op_a : '0;
      end
`endif
   end

   always_comb begin
      fix_val = '0;
      if (is_div_op(f3_q)) begin
         fix_val = f3_q[1] ? hi_out : lo_out;
      end else if (f3_q == F3_MUL) begin
         fix_val = prod_fixed[XLEN-1:0];
      end else begin
         fix_val = prod_fixed[2*XLEN-1:XLEN];
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start) state_next = ST_PREP;
         ST_PREP: state_next = short_cut ? ST_DONE : ST_RUN;
         ST_RUN:  if (cnt == '0) state_next = ST_FIX;
         ST_FIX:  state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
      if (flush) state_next = ST_IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         acc    <= '0;
         b_q    <= '0;
         f3_q   <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            ST_PREP: begin
               f3_q   <= funct3;
               sign_a <= prep_sa;
               sign_b <= prep_sb;
               cnt    <= CNT_W'(XLEN - 1);
               if (is_div_op(funct3)) begin
                  acc <= {{XLEN{1'b0}}, lo_out};
                  b_q <= hi_out;
               end else begin
                  acc <= {{XLEN{1'b0}}, hi_out};
                  b_q <= lo_out;
               end
               if (short_cut && !flush) result <= short_val;
            end
            ST_RUN: begin
               acc <= is_div_op(f3_q) ? div_step : mul_step;
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
            end
            ST_FIX: begin
               if (!flush) result <= fix_val;
            end
            default: ;
         endcase
      end
   end

   assign busy  = (state != ST_IDLE);
   assign stall = ((state == ST_IDLE) && start) || (state == ST_PREP) ||
                  (state == ST_RUN) || (state == ST_FIX);
   assign done  = (state == ST_DONE);

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed RV32M vectors, flush/abort and async-reset cases.
module tb_muldiv_seq;
   import muldiv_seq_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        flush;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;
   int cycle_cnt = 0;
   logic [31:0] last_result = '0;

   typedef struct {
      string       name;
      logic [31:0] exp_val;
      int          lat;
      int          issued;
   } sb_t;

   sb_t sb[$];
   sb_t mon_e;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int EARLY_LAT = 2;
`else
   localparam int EARLY_LAT = 35;
`endif

   muldiv_seq #(.XLEN(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .flush  (flush),
      .busy   (busy),
      .stall  (stall),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            check("spurious_done", done, 1'b0);
         end else begin
            mon_e = sb.pop_front();
            check({mon_e.name, "_result"}, result, mon_e.exp_val);
            check({mon_e.name, "_latency"}, cycle_cnt - mon_e.issued, mon_e.lat);
         end
      end
   end

   task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_val, input int lat,
                        input int poke);
      @(negedge clk);
      funct3 = f3;
      op_a   = a;
      op_b   = b;
      start  = 1'b1;
      sb.push_back('{name: name, exp_val: exp_val, lat: lat, issued: cycle_cnt});
      last_result = exp_val;
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i < 80 && sb.size() > 0; i++) begin
         start = (i == poke);
         @(negedge clk);
      end
      start = 1'b0;
      if (sb.size() > 0) begin
         check({name, "_timeout"}, sb.size(), 0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      flush  = 1'b0;
      funct3 = F3_MUL;
      op_a   = '0;
      op_b   = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_stall", stall, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_result", result, 32'h0);

      // MUL 7 * -3 with stall profile
      @(negedge clk);
      funct3 = F3_MUL;
      op_a   = 32'd7;
      op_b   = 32'hFFFF_FFFD;
      start  = 1'b1;
      sb.push_back('{name: "mul_7_m3", exp_val: 32'hFFFF_FFEB, lat: 35, issued: cycle_cnt});
      last_result = 32'hFFFF_FFEB;
      #1 check("mul_stall_at_start", stall, 1'b1);
      for (int k = 1; k <= 35; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 1)  check("mul_busy_prep", busy, 1'b1);
         if (k == 34) check("mul_stall_fix", stall, 1'b1);
         if (k == 35) check("mul_stall_done", stall, 1'b0);
      end
      @(negedge clk);
      check("mul_7_m3_completed", sb.size(), 0);
      sb.delete();

      issue("mulh_min_min",    F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35, 0);
      issue("mulhu_max_max",   F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 0);
      issue("mulhsu_m1_max",   F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, 0);
      issue("mulhu_2p16_sq",   F3_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 35, 0);
      issue("div_m7_2",        F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 35, 0);
      issue("rem_m7_2",        F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 35, 0);
      issue("div_7_m2",        F3_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 35, 0);
      issue("rem_7_m2",        F3_REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 35, 0);
      issue("divu_100_7",      F3_DIVU,   32'd100,       32'd7,         32'd14,        35, 0);
      issue("remu_100_7",      F3_REMU,   32'd100,       32'd7,         32'd2,         35, 0);
      issue("divu_max_16",     F3_DIVU,   32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 35, 0);
      issue("remu_max_16",     F3_REMU,   32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 35, 0);
      issue("div_5_0",         F3_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 2,  0);
      issue("rem_5_0",         F3_REM,    32'd5,         32'd0,         32'd5,         2,  0);
      issue("divu_5_0",        F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 2,  0);
      issue("div_ovf",         F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,  0);
      issue("rem_ovf",         F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2,  0);
      issue("mul_0_9",         F3_MUL,    32'd0,         32'd9,         32'd0,         EARLY_LAT, 0);
      issue("divu_3_10",       F3_DIVU,   32'd3,         32'd10,        32'd0,         EARLY_LAT, 0);
      issue("remu_3_10",       F3_REMU,   32'd3,         32'd10,        32'd3,         EARLY_LAT, 0);

      // flush at RUN cycle 10: back to IDLE, no done, result unchanged
      @(negedge clk);
      funct3 = F3_DIVU;
      op_a   = 32'd100;
      op_b   = 32'd7;
      start  = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 11) flush = 1'b1;
      end
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", busy, 1'b0);
      check("flush_result_held", result, last_result);
      repeat (40) @(negedge clk);
      check("flush_stall_idle", stall, 1'b0);

      // start and flush together in IDLE: flush wins
      @(negedge clk);
      start = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      check("start_flush_busy", busy, 1'b0);

      // normal op after flush, with start pulsed while busy
      issue("divu_after_flush", F3_DIVU, 32'd100, 32'd7, 32'd14, 35, 5);
      issue("mul_after_poke",   F3_MUL,  32'd6,   32'd7, 32'd42, 35, 20);

      // async reset asserted between edges mid-RUN
      @(negedge clk);
      funct3 = F3_MULHU;
      op_a   = 32'hFFFF_FFFF;
      op_b   = 32'hFFFF_FFFF;
      start  = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("pre_rst_stall", stall, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_busy", busy, 1'b0);
      check("async_rst_stall", stall, 1'b0);
      check("async_rst_done", done, 1'b0);
      check("async_rst_result", result, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      last_result = '0;

      issue("mul_after_rst", F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
